// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: request, response and shared-port signals between the
// fetch stage, the data stage and the single physical memory port.
// slave  = arbiter side, master = environment (requesters + memory).
interface mem_port_arbiter_if;
  // fetch requester
  logic [15:0] if_memaddr;
  logic        if_memread;
  logic [1:0]  if_mem_byte_enable;
  logic        if_mem_resp;
  logic [15:0] if_mem_rdata;
  // data-stage requester
  logic [15:0] mem_memaddr;
  logic        mem_memread;
  logic        mem_memwrite;
  logic [1:0]  mem_mem_byte_enable;
  logic [15:0] mem_mem_wdata;
  logic        mem_mem_resp;
  logic [15:0] mem_mem_rdata;
  // shared physical port
  logic [15:0] pmem_address;
  logic        pmem_read;
  logic        pmem_write;
  logic [1:0]  pmem_byte_enable;
  logic [15:0] pmem_wdata;
  logic        pmem_resp;
  logic [15:0] pmem_rdata;

  modport slave (
    input  if_memaddr, if_memread, if_mem_byte_enable,
    output if_mem_resp, if_mem_rdata,
    input  mem_memaddr, mem_memread, mem_memwrite, mem_mem_byte_enable, mem_mem_wdata,
    output mem_mem_resp, mem_mem_rdata,
    output pmem_address, pmem_read, pmem_write, pmem_byte_enable, pmem_wdata,
    input  pmem_resp, pmem_rdata
  );

  modport master (
    output if_memaddr, if_memread, if_mem_byte_enable,
    input  if_mem_resp, if_mem_rdata,
    output mem_memaddr, mem_memread, mem_memwrite, mem_mem_byte_enable, mem_mem_wdata,
    input  mem_mem_resp, mem_mem_rdata,
    input  pmem_address, pmem_read, pmem_write, pmem_byte_enable, pmem_wdata,
    output pmem_resp, pmem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the fetch (IF) and data
// (MEM) stages. One transaction in flight at a time; the winner's request is
// captured at grant so the port is immune to later requester changes.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on contention instead of
// MEM-first priority with an IF starvation limit.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8  // 1..15
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_e;

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [1:0]  be_q, be_d;
  logic [3:0]  starve_q, starve_d;
  logic        last_if_q, last_if_d;  // 1: most recent grant went to IF

  logic if_pend, mem_pend, grant_if, grant_mem;

  // Winner selection, evaluated every cycle but only acted on in IDLE
  always_comb begin
    if_pend  = bus.if_memread;
    mem_pend = bus.mem_memread | bus.mem_memwrite;
    grant_if = 1'b0;
    if (if_pend && !mem_pend) begin
      grant_if = 1'b1;
    end else if (if_pend && mem_pend) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_if = !last_if_q;
`else
      grant_if = (starve_q == 4'(STARVE_LIMIT));
`endif
    end
    grant_mem = mem_pend && !grant_if;
  end

  // Next state and request capture
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    read_d    = read_q;
    write_d   = write_q;
    be_d      = be_q;
    starve_d  = starve_q;
    last_if_d = last_if_q;
    case (state_q)
      IDLE: begin
        if (grant_if) begin
          state_d   = BUSY_IF;
          addr_d    = bus.if_memaddr;
          read_d    = 1'b1;
          write_d   = 1'b0;
          be_d      = bus.if_mem_byte_enable;
          wdata_d   = 16'h0;
          starve_d  = 4'h0;
          last_if_d = 1'b1;
        end else if (grant_mem) begin
          state_d   = BUSY_MEM;
          addr_d    = bus.mem_memaddr;
          // write wins if both strobes are raised
          write_d   = bus.mem_memwrite;
          read_d    = !bus.mem_memwrite;
          be_d      = bus.mem_mem_byte_enable;
          wdata_d   = bus.mem_mem_wdata;
          last_if_d = 1'b0;
          if (if_pend && starve_q != 4'hF) starve_d = starve_q + 4'd1;
        end
      end
      BUSY_IF, BUSY_MEM: begin
        if (bus.pmem_resp) begin
          state_d = IDLE;
          read_d  = 1'b0;
          write_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured-request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= 16'h0;
      wdata_q   <= 16'h0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      be_q      <= 2'b00;
      starve_q  <= 4'h0;
      last_if_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      read_q    <= read_d;
      write_q   <= write_d;
      be_q      <= be_d;
      starve_q  <= starve_d;
      last_if_q <= last_if_d;
    end
  end

  // Port drive from captured registers; responses routed to the owner only
  always_comb begin
    bus.pmem_address     = addr_q;
    bus.pmem_read        = read_q;
    bus.pmem_write       = write_q;
    bus.pmem_byte_enable = be_q;
    bus.pmem_wdata       = wdata_q;
    bus.if_mem_resp      = (state_q == BUSY_IF)  && bus.pmem_resp;
    bus.mem_mem_resp     = (state_q == BUSY_MEM) && bus.pmem_resp;
    bus.if_mem_rdata     = bus.if_mem_resp  ? bus.pmem_rdata : 16'h0;
    bus.mem_mem_rdata    = bus.mem_mem_resp ? bus.pmem_rdata : 16'h0;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 8, legal 1..15; max consecutive contended MEM grants before IF is forced (fixed-priority mode only).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 if_memaddr  in  16  fetch address.
REQ-006 if_memread  in  1  fetch read request.
REQ-007 if_mem_byte_enable  in  2  fetch byte enables.
REQ-008 if_mem_resp  out  1  fetch done pulse.
REQ-009 if_mem_rdata  out  16  fetch read data.
REQ-010 mem_memaddr  in  16  data-stage address.
REQ-011 mem_memread  in  1  data read request.
REQ-012 mem_memwrite  in  1  data write request.
REQ-013 mem_mem_byte_enable  in  2  data byte enables.
REQ-014 mem_mem_wdata  in  16  data write data.
REQ-015 mem_mem_resp  out  1  data done pulse.
REQ-016 mem_mem_rdata  out  16  data read data.
REQ-017 pmem_address  out  16  shared port address.
REQ-018 pmem_read  out  1  shared port read.
REQ-019 pmem_write  out  1  shared port write.
REQ-020 pmem_byte_enable  out  2  shared port byte enables.
REQ-021 pmem_wdata  out  16  shared port write data.
REQ-022 pmem_resp  in  1  shared port completion.
REQ-023 pmem_rdata  in  16  shared port read data.

Function
REQ-024 States: IDLE, BUSY_IF, BUSY_MEM; a requester is pending when its read (or write) is high.
REQ-025 In IDLE with any request pending, the arbiter SHALL pick a winner, register its address/read/write/byte-enable/wdata, and enter BUSY_IF or BUSY_MEM at the next edge.
REQ-026 pmem_* outputs SHALL come only from the captured registers; requester input changes after grant SHALL NOT affect the port.
REQ-027 pmem_read and pmem_write SHALL be 0 in IDLE; IF grants capture write=0, wdata=0.
REQ-028 If mem_memread and mem_memwrite are both high at grant, only write SHALL be captured.
REQ-029 In BUSY_X with pmem_resp=1, X_resp SHALL be 1 that same cycle, X_rdata=pmem_rdata, state returns to IDLE at the next edge.
REQ-030 X_resp SHALL be a single-cycle pulse; X_rdata SHALL be 16'h0 when X_resp=0; the non-granted resp SHALL stay 0.
REQ-031 At least one IDLE cycle (pmem_read=pmem_write=0) SHALL separate back-to-back transactions; minimum latency request->resp = 2 cycles.
REQ-032 pmem_resp in IDLE SHALL be ignored (no resp pulse, no state change).
REQ-033 Only MEM pending -> MEM; only IF pending -> IF; contention resolved per REQ-037/038.
REQ-034 A 4-bit starvation counter SHALL increment on each MEM grant made while IF is pending, and clear on every IF grant.

Reset
REQ-035 rst SHALL force IDLE, clear all captured registers and the starvation counter, and set last-grant to IF; all outputs 0 at the edge after rst.
REQ-036 rst during BUSY_* SHALL abort without any resp pulse; later pmem_resp is ignored per REQ-032.

Configuration
REQ-037 Without ARB_ROUND_ROBIN_EN: on contention MEM wins unless starvation counter == STARVE_LIMIT, in which case IF wins.
REQ-038 With ARB_ROUND_ROBIN_EN: on contention the requester not granted last wins; starvation counter and STARVE_LIMIT SHALL have no effect; last-grant updates on every grant.

Verification
REQ-039 Reset, IF read 0x3000, pmem_resp after 3 cycles, rdata 0x1234 -> pmem_address=0x3000 one cycle after request, if_mem_resp one cycle with rdata 0x1234, then IDLE.
REQ-040 IF and MEM read both held, fixed priority, STARVE_LIMIT=2 -> grant order MEM, MEM, IF, MEM, MEM, IF; one IDLE cycle between each.
REQ-041 Same with ARB_ROUND_ROBIN_EN -> order MEM, IF, MEM, IF.
REQ-042 MEM write 0x5000 data 0xBEEF be 2'b01, inputs changed after grant -> pmem holds 0x5000/0xBEEF/2'b01/write=1 until pmem_resp; mem_mem_rdata stays 0.
REQ-043 rst asserted in BUSY_MEM, pmem_resp arrives next cycle -> no resp pulses, pmem_read/write 0, state IDLE.
REQ-044 MEM read and write both high -> pmem_write=1, pmem_read=0.
